// File: rtl/imem_arbiter_pkg.sv
// rtl/imem_arbiter_pkg.sv - shared state encoding, requester IDs and helpers for imem_arbiter
package imem_arbiter_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_ISSUE = ISSUE,
    S_WAIT  = WAIT,
    S_RESP  = RESP
  } state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LOAD  = 1'b1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/imem_lat_cnt.sv
// rtl/imem_lat_cnt.sv - loadable down-counter timing the memory read latency
module imem_lat_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - fetch/loader arbiter for the single-ported instruction memory
// Optional performance counters are enabled by defining IMEM_ARB_PERF_EN.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  input  logic              f_flush_i,
  output logic              f_stall_o,
  output logic              f_v_o,
  output logic [DATA_W-1:0] f_data_o,
  input  logic              l_req_i,
  input  logic              l_we_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [DATA_W-1:0] l_wdata_i,
  output logic              l_ack_o,
  output logic [DATA_W-1:0] l_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_fgrant_o,
  output logic [31:0]       perf_lgrant_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t            state;
  logic              owner;
  logic              req_we;
  logic              kill;
  logic [SW-1:0]     starve;
  logic [DATA_W-1:0] f_data_q;
  logic [DATA_W-1:0] l_rdata_q;

  logic arb_pt, grant_f, grant_l, resp_f, resp_l, lat_zero, lat_dec;

  // Arbitration happens in IDLE and RESP so a new access can follow RESP directly.
  assign arb_pt  = (state == S_IDLE) || (state == S_RESP);
  assign grant_l = arb_pt && l_req_i && (!f_req_i || starve == SW'(STARVE_MAX));
  assign grant_f = arb_pt && f_req_i && !grant_l;
  assign resp_f  = (state == S_RESP) && (owner == REQ_FETCH);
  assign resp_l  = (state == S_RESP) && (owner == REQ_LOAD);
  assign lat_dec = (state == S_ISSUE) || (state == S_WAIT);

  assign f_v_o     = resp_f && !kill && !f_flush_i;
  assign f_data_o  = resp_f ? mem_rdata_i : f_data_q;
  assign f_stall_o = f_req_i && !f_v_o;
  assign l_rdata_o = (resp_l && !req_we) ? mem_rdata_i : l_rdata_q;

  imem_lat_cnt #(.W(CW)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_f || grant_l),
    .load_val (CW'(MEM_LAT - 1)),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      owner       <= REQ_FETCH;
      req_we      <= 1'b0;
      kill        <= 1'b0;
      starve      <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      l_ack_o     <= 1'b0;
      f_data_q    <= '0;
      l_rdata_q   <= '0;
    end else begin
      mem_en_o <= 1'b0;
      mem_we_o <= 1'b0;
      l_ack_o  <= 1'b0;

      if (!l_req_i || grant_l) begin
        starve <= '0;
      end else if (grant_f && starve != SW'(STARVE_MAX)) begin
        starve <= starve + SW'(1);
      end

      case (state)
        S_IDLE, S_RESP: begin
          if (grant_l) begin
            state       <= S_ISSUE;
            owner       <= REQ_LOAD;
            req_we      <= l_we_i;
            mem_en_o    <= 1'b1;
            mem_we_o    <= l_we_i;
            mem_addr_o  <= l_addr_i;
            mem_wdata_o <= l_wdata_i;
          end else if (grant_f) begin
            state      <= S_ISSUE;
            owner      <= REQ_FETCH;
            req_we     <= 1'b0;
            mem_en_o   <= 1'b1;
            mem_addr_o <= f_addr_i;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (lat_zero) begin
            state   <= S_RESP;
            l_ack_o <= (owner == REQ_LOAD);
          end else begin
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A killed fetch runs out its memory timing silently; the flag dies with RESP.
      if (state == S_RESP) begin
        kill <= 1'b0;
      end else if (state != S_IDLE && owner == REQ_FETCH && f_flush_i) begin
        kill <= 1'b1;
      end

      if (resp_f) begin
        f_data_q <= mem_rdata_i;
      end
      if (resp_l && !req_we) begin
        l_rdata_q <= mem_rdata_i;
      end
    end
  end

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fgrant_o <= '0;
      perf_lgrant_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (grant_f)   perf_fgrant_o <= sat_inc32(perf_fgrant_o);
      if (grant_l)   perf_lgrant_o <= sat_inc32(perf_lgrant_o);
      if (f_stall_o) perf_stall_o  <= sat_inc32(perf_stall_o);
    end
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed bench for imem_arbiter at MEM_LAT=2 and MEM_LAT=1
module tb_imem_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req, f_flush, l_req, l_we;
  logic [15:0] f_addr, l_addr;
  logic [31:0] l_wdata;
  logic        f_stall, f_v, l_ack, mem_en, mem_we;
  logic [31:0] f_data, l_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  logic        g_req;
  logic [15:0] g_addr;
  logic        g_stall, g_v, g_lack, g_en, g_we;
  logic [31:0] g_data, g_lrdata, g_wdata, g_rdata;
  logic [15:0] g_mem_addr;

  int n_checks = 0;
  int n_errors = 0;

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] pf0, pl0, ps0, pf1, pl1, ps1;
`endif

  imem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_flush_i(f_flush),
    .f_stall_o(f_stall), .f_v_o(f_v), .f_data_o(f_data),
    .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
    .l_ack_o(l_ack), .l_rdata_o(l_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef IMEM_ARB_PERF_EN
    , .perf_fgrant_o(pf0), .perf_lgrant_o(pl0), .perf_stall_o(ps0)
`endif
  );

  imem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .f_req_i(g_req), .f_addr_i(g_addr), .f_flush_i(1'b0),
    .f_stall_o(g_stall), .f_v_o(g_v), .f_data_o(g_data),
    .l_req_i(1'b0), .l_we_i(1'b0), .l_addr_i(16'h0), .l_wdata_i(32'h0),
    .l_ack_o(g_lack), .l_rdata_o(g_lrdata),
    .mem_en_o(g_en), .mem_we_o(g_we), .mem_addr_o(g_mem_addr),
    .mem_wdata_o(g_wdata), .mem_rdata_i(g_rdata)
`ifdef IMEM_ARB_PERF_EN
    , .perf_fgrant_o(pf1), .perf_lgrant_o(pl1), .perf_stall_o(ps1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: unwritten words read back as C0DE0000 | addr.
  logic [31:0] wr_mem [0:255];
  logic        wr_vld [0:255];
  logic [31:0] p1, p2, q1;

  initial begin
    for (int i = 0; i < 256; i++) wr_vld[i] = 1'b0;
  end

  function automatic logic [31:0] rd(input logic [15:0] a);
    rd = (wr_vld[a[7:0]] === 1'b1) ? wr_mem[a[7:0]] : (32'hC0DE_0000 | {16'h0, a});
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_mem[mem_addr[7:0]] <= mem_wdata;
      wr_vld[mem_addr[7:0]] <= 1'b1;
    end
    p1 <= (mem_en && !mem_we) ? rd(mem_addr) : 32'hBAD0_BAD0;
    p2 <= p1;
    q1 <= (g_en && !g_we) ? rd(g_mem_addr) : 32'hBAD1_BAD1;
  end
  assign mem_rdata = p2;
  assign g_rdata   = q1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  logic [15:0] gseq [0:9];
  int ng;

  initial begin
    rst = 1'b0; f_req = 1'b1; f_addr = '0; f_flush = 1'b0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    g_req = 1'b0; g_addr = '0;
    #3;
    chk("rst_stall", {31'd0, f_stall}, 32'd1);
    chk("rst_en", {31'd0, mem_en}, 32'd0);
    chk("rst_fv", {31'd0, f_v}, 32'd0);
    chk("rst_ack", {31'd0, l_ack}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_fdata", f_data, 32'd0);
    f_req = 1'b0;
    nxt(); rst = 1'b1;
    nxt();

    // Fetch alone at 0x10
    nxt(); f_req = 1'b1; f_addr = 16'h10; #1;
    chk("f1_c0_stall", {31'd0, f_stall}, 32'd1);
    chk("f1_c0_en", {31'd0, mem_en}, 32'd0);
    nxt(); #1;
    chk("f1_c1_en", {31'd0, mem_en}, 32'd1);
    chk("f1_c1_addr", {16'd0, mem_addr}, 32'h10);
    chk("f1_c1_stall", {31'd0, f_stall}, 32'd1);
    nxt(); #1;
    chk("f1_c2_en", {31'd0, mem_en}, 32'd0);
    chk("f1_c2_stall", {31'd0, f_stall}, 32'd1);
    chk("f1_c2_fv", {31'd0, f_v}, 32'd0);
    nxt(); f_req = 1'b0; #1;
    chk("f1_c3_fv", {31'd0, f_v}, 32'd1);
    chk("f1_c3_data", f_data, 32'hC0DE_0010);
    nxt(); #1;
    chk("f1_c4_fv", {31'd0, f_v}, 32'd0);
    chk("f1_c4_hold", f_data, 32'hC0DE_0010);

    // Flush in WAIT, refetch 0x40 from RESP
    nxt(); f_req = 1'b1; f_addr = 16'h20;
    nxt();
    nxt(); f_flush = 1'b1; #1;
    chk("fl_c2_fv", {31'd0, f_v}, 32'd0);
    nxt(); f_flush = 1'b0; f_addr = 16'h40; #1;
    chk("fl_c3_fv", {31'd0, f_v}, 32'd0);
    chk("fl_c3_stall", {31'd0, f_stall}, 32'd1);
    nxt(); #1;
    chk("fl_c4_en", {31'd0, mem_en}, 32'd1);
    chk("fl_c4_addr", {16'd0, mem_addr}, 32'h40);
    nxt();
    nxt(); f_req = 1'b0; #1;
    chk("fl_c6_fv", {31'd0, f_v}, 32'd1);
    chk("fl_c6_data", f_data, 32'hC0DE_0040);

    // Flush during RESP kills that fetch; flush in IDLE is ignored
    nxt(); f_req = 1'b1; f_addr = 16'h44;
    nxt();
    nxt();
    nxt(); f_req = 1'b0; f_flush = 1'b1; #1;
    chk("flr_fv", {31'd0, f_v}, 32'd0);
    nxt(); f_req = 1'b1; f_addr = 16'h48; #1;
    chk("fli_fv", {31'd0, f_v}, 32'd0);
    nxt(); f_flush = 1'b0; #1;
    chk("fli_en", {31'd0, mem_en}, 32'd1);
    chk("fli_addr", {16'd0, mem_addr}, 32'h48);
    nxt();
    nxt(); f_req = 1'b0; #1;
    chk("fli_fv_resp", {31'd0, f_v}, 32'd1);
    chk("fli_data", f_data, 32'hC0DE_0048);

    // Loader write then read of 0x5
    nxt(); l_req = 1'b1; l_we = 1'b1; l_addr = 16'h5; l_wdata = 32'hDEAD_BEEF; #1;
    chk("lw_c0_ack", {31'd0, l_ack}, 32'd0);
    nxt(); #1;
    chk("lw_c1_en", {31'd0, mem_en}, 32'd1);
    chk("lw_c1_we", {31'd0, mem_we}, 32'd1);
    chk("lw_c1_addr", {16'd0, mem_addr}, 32'h5);
    chk("lw_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
    nxt(); #1;
    chk("lw_c2_ack", {31'd0, l_ack}, 32'd0);
    nxt(); l_we = 1'b0; #1;
    chk("lw_c3_ack", {31'd0, l_ack}, 32'd1);
    nxt(); #1;
    chk("lr_c4_en", {31'd0, mem_en}, 32'd1);
    chk("lr_c4_we", {31'd0, mem_we}, 32'd0);
    nxt(); f_flush = 1'b1;
    nxt(); f_flush = 1'b0; l_req = 1'b0; #1;
    chk("lr_c6_ack", {31'd0, l_ack}, 32'd1);
    chk("lr_c6_rdata", l_rdata, 32'hDEAD_BEEF);
    nxt(); #1;
    chk("lr_c7_ack", {31'd0, l_ack}, 32'd0);
    chk("lr_c7_hold", l_rdata, 32'hDEAD_BEEF);

    // Both requesters held: F,F,F,F,L,F,F,F,F,L
    nxt(); f_req = 1'b1; f_addr = 16'h30; l_req = 1'b1; l_we = 1'b0; l_addr = 16'h31;
    ng = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      nxt(); #1;
      if (mem_en) begin
        gseq[ng] = mem_addr;
        ng++;
      end
    end
    chk("starve_count", ng, 10);
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("starve_g%0d", i), {16'd0, gseq[i]}, (i == 4 || i == 9) ? 32'h31 : 32'h30);
    end
    f_req = 1'b0; l_req = 1'b0;
    repeat (6) nxt();

    // Reset during WAIT
    nxt(); f_req = 1'b1; f_addr = 16'h50;
    nxt();
    nxt(); rst = 1'b0; #1;
    chk("rw_en", {31'd0, mem_en}, 32'd0);
    chk("rw_fv", {31'd0, f_v}, 32'd0);
    chk("rw_stall", {31'd0, f_stall}, 32'd1);
    chk("rw_addr", {16'd0, mem_addr}, 32'd0);
    chk("rw_fdata", f_data, 32'd0);
    chk("rw_lrdata", l_rdata, 32'd0);
    nxt(); rst = 1'b1; #1;
    chk("rw_c3_en", {31'd0, mem_en}, 32'd0);
    chk("rw_c3_fv", {31'd0, f_v}, 32'd0);
    nxt(); #1;
    chk("rw_c4_en", {31'd0, mem_en}, 32'd1);
    chk("rw_c4_addr", {16'd0, mem_addr}, 32'h50);
    chk("rw_c4_fv", {31'd0, f_v}, 32'd0);
    nxt(); #1;
    chk("rw_c5_fv", {31'd0, f_v}, 32'd0);
    chk("rw_c5_ack", {31'd0, l_ack}, 32'd0);
    nxt(); f_req = 1'b0; #1;
    chk("rw_c6_fv", {31'd0, f_v}, 32'd1);
    chk("rw_c6_data", f_data, 32'hC0DE_0050);

    // MEM_LAT=1 back-to-back fetches
    nxt(); g_req = 1'b1; g_addr = 16'h60;
    nxt(); #1;
    chk("l1_c1_en", {31'd0, g_en}, 32'd1);
    chk("l1_c1_addr", {16'd0, g_mem_addr}, 32'h60);
    nxt(); g_addr = 16'h61; #1;
    chk("l1_c2_fv", {31'd0, g_v}, 32'd1);
    chk("l1_c2_data", g_data, 32'hC0DE_0060);
    nxt(); #1;
    chk("l1_c3_fv", {31'd0, g_v}, 32'd0);
    chk("l1_c3_en", {31'd0, g_en}, 32'd1);
    chk("l1_c3_addr", {16'd0, g_mem_addr}, 32'h61);
    chk("l1_c3_stall", {31'd0, g_stall}, 32'd1);
    nxt(); g_addr = 16'h62; #1;
    chk("l1_c4_fv", {31'd0, g_v}, 32'd1);
    chk("l1_c4_data", g_data, 32'hC0DE_0061);
    chk("l1_c4_lack", {31'd0, g_lack}, 32'd0);
    nxt();
    nxt(); g_req = 1'b0; #1;
    chk("l1_c6_fv", {31'd0, g_v}, 32'd1);
    chk("l1_c6_data", g_data, 32'hC0DE_0062);
    nxt(); #1;
    chk("l1_c7_fv", {31'd0, g_v}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-ported instruction memory between two requesters:
  - the instruction fetch stage (fetch side);
  - the program loader/debug port (loader side).
- Sequences each access: ISSUE, then WAIT, then RESP.
- Generates the fetch stall and fetch-valid qualifiers.
- Honours branch flushes by discarding killed in-flight fetches.
- Sits between the fetch stage and the imem macro.

Parameters:
- ADDR_W, 16, instruction address width.
- DATA_W, 32, instruction/data word width.
- MEM_LAT, 2, memory read latency in cycles from the mem_en_o cycle to the mem_rdata_i-valid cycle. Legal values are 1 or more.
- STARVE_MAX, 4, number of consecutive fetch grants allowed while a loader request is pending.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- f_req_i  in  1  fetch requests a read
- f_addr_i  in  ADDR_W  fetch address
- f_flush_i  in  1  branch taken; kill the in-flight fetch
- f_stall_o  out  1  fetch must hold its state
- f_v_o  out  1  f_data_o valid (one-cycle pulse)
- f_data_o  out  DATA_W  fetched instruction
- l_req_i  in  1  loader access request
- l_we_i  in  1  loader write (1) or read (0)
- l_addr_i  in  ADDR_W  loader address
- l_wdata_i  in  DATA_W  loader write data
- l_ack_o  out  1  loader access complete (one-cycle pulse)
- l_rdata_o  out  DATA_W  loader read data, valid with l_ack_o
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en_o

Behaviour:
- Reset:
  - state = IDLE; starvation counter = 0; kill flag = 0.
  - All outputs are 0, except f_stall_o = f_req_i (combinational).
  - Reset mid-access drops the access; no v/ack is produced for it.
- States:
  - IDLE: no access in progress.
  - ISSUE: 1 cycle. mem_en_o=1; mem_addr_o, mem_we_o and mem_wdata_o come from the granted requester's registered request.
  - WAIT: MEM_LAT-1 cycles, counted down. WAIT is skipped when MEM_LAT=1.
  - RESP: 1 cycle; mem_rdata_i is valid during this cycle.
- Arbitration:
  - Evaluated in IDLE and in RESP, so back-to-back accesses are possible.
  - Winner enters ISSUE next cycle; if there is no request, go to IDLE.
  - Priority: fetch > loader, except that the loader wins when the starvation counter equals STARVE_MAX.
- Starvation counter:
  - Increments on each fetch grant while l_req_i=1.
  - Clears on a loader grant, or whenever l_req_i=0.
  - Saturates at STARVE_MAX.
- Request latching:
  - Winner's address, we and wdata are registered at grant.
  - Requesters hold req and address stable until their v/ack pulse.
- Fetch response:
  - In RESP for a fetch: f_v_o = ~kill & ~f_flush_i, and f_data_o = mem_rdata_i (pass-through).
  - Otherwise f_v_o = 0 and f_data_o holds its last value.
- Kill flag:
  - Set when f_flush_i=1 while a fetch is in ISSUE, WAIT or RESP.
  - Cleared on leaving RESP.
  - A killed fetch still completes its memory timing but produces no f_v_o.
- Stall: f_stall_o = f_req_i & ~f_v_o.
- Loader response:
  - In RESP for a loader access: l_ack_o=1.
  - For a read, l_rdata_o = mem_rdata_i, registered and held until the next loader ack.
  - Writes ack at the same time as reads.
- Flush in IDLE: no effect.
- Flush with the loader granted: no effect on the loader access.
- Simultaneous flush and new fetch request in RESP: the new fetch is arbitrated normally.
- Latency: request-to-v/ack = MEM_LAT+1 cycles. Sustained single-requester throughput is one access per MEM_LAT+1 cycles.

Optional Feature:
- Macro: IMEM_ARB_PERF_EN.
- When defined, adds three saturating counters, each exposed on a 32-bit output port and cleared by reset:
  - perf_fgrant_o: fetch grants.
  - perf_lgrant_o: loader grants.
  - perf_stall_o: cycles with f_stall_o=1.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared params include: state encoding localparams (IDLE, ISSUE, WAIT, RESP) and requester-ID constants (REQ_FETCH, REQ_LOAD).
- Sub-module imem_lat_cnt: loadable down-counter for WAIT, loaded with MEM_LAT-1, flags zero.

Test Plan:
- Fetch alone, MEM_LAT=2, f_req_i=1 at cycle 0 with addr 0x10:
  - mem_en_o=1, mem_addr_o=0x10 at cycle 1.
  - f_v_o=1 with f_data_o = the mem word at cycle 3.
  - f_stall_o=1 during cycles 0–2.
- Flush at cycle 2 of that fetch: f_v_o stays 0 at cycle 3; a refetch of new address 0x40 issues at cycle 4.
- Loader write 0xDEADBEEF to 0x5 while idle:
  - mem_we_o=1 with that data in ISSUE.
  - l_ack_o pulses at request+3.
  - A subsequent loader read of 0x5 returns 0xDEADBEEF on l_rdata_o.
- f_req_i and l_req_i held continuously, STARVE_MAX=4: grant sequence is F,F,F,F,L,F,F,F,F,L.
- Reset asserted during WAIT: outputs are 0 immediately; after release the held fetch reissues from IDLE with no spurious v/ack.
- MEM_LAT=1: ISSUE is followed directly by RESP; back-to-back fetches give f_v_o every 2 cycles.
